// File: rtl/block_refill_responder_pkg.sv
// Shared definitions for the refill responder: block geometry, address width
// and FSM state encodings (tag/index/offset split common to the cache levels).
package block_refill_responder_pkg;

   localparam int ADDR_W    = 32;
   localparam int BLK_WORDS = 16;
   localparam int OFS_W     = $clog2(BLK_WORDS);
   localparam int BASE_W    = ADDR_W - OFS_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_BURST = 2'd2;

   typedef logic [OFS_W-1:0]  ofs_t;
   typedef logic [BASE_W-1:0] base_t;

endpackage

// File: rtl/block_refill_responder_if.sv
// Refill request/response channel plus the backing-store write path between
// the last-level cache (master) and the memory-side responder (slave).
interface block_refill_responder_if #(
   parameter int WORD_W = 32
);
   import block_refill_responder_pkg::*;

   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              resp_valid;
   logic [WORD_W-1:0] resp_data;
   logic [OFS_W-1:0]  resp_word;
   logic              resp_last;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;

   modport master (
      output req_valid, req_addr, wr_en, wr_addr, wr_data,
      input  req_ready, resp_valid, resp_data, resp_word, resp_last
   );

   modport slave (
      input  req_valid, req_addr, wr_en, wr_addr, wr_data,
      output req_ready, resp_valid, resp_data, resp_word, resp_last
   );

endinterface

// File: rtl/block_refill_responder_mem_array_1r1w.sv
// Backing word store: one synchronous read port, one write port, read-before-write
// on a same-edge collision. Addresses alias on their low log2(DEPTH) bits.
module block_refill_responder_mem_array_1r1w #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WORD_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WORD_W-1:0] rd_data_o
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rd_data_q;

   // NOTE: the array itself is never reset (a reset would turn it into flops);
   // only the read register is cleared so the output is defined after reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
   end

   // Both blocks sample mem_q before the write lands, giving old data on a collision.
   always_ff @(posedge clk) begin
      if (rst)          rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i[IDX_W-1:0]];
   end

   assign rd_data_o = rd_data_q;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{wr_addr_i[ADDR_W-1:IDX_W], rd_addr_i[ADDR_W-1:IDX_W]};

endmodule

// File: rtl/block_refill_responder.sv
// Memory-side refill responder: accepts one block read, waits LATENCY cycles,
// then streams the 16-word block critical word first, wrapping within the block.
module block_refill_responder
   import block_refill_responder_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter int MEM_WORDS = 4096,
   parameter int LATENCY   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   block_refill_responder_if.slave  bus
);

   localparam int CNT_W = $clog2(LATENCY + 1);

   logic [1:0]       state_q, state_d;
   logic             req_ready_q, req_ready_d;
   logic             resp_valid_q, resp_valid_d;
   logic             resp_last_q, resp_last_d;
   ofs_t             resp_word_q, resp_word_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ofs_t             beat_q, beat_d;
   ofs_t             ofs_q, ofs_d;
   base_t            base_q, base_d;
   logic             issue;
   logic [WORD_W-1:0] rd_data;

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      resp_last_d  = 1'b0;
      resp_word_d  = resp_word_q;
      cnt_d        = cnt_q;
      beat_d       = beat_q;
      ofs_d        = ofs_q;
      base_d       = base_q;
      issue        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               base_d      = bus.req_addr[ADDR_W-1:OFS_W];
               ofs_d       = bus.req_addr[OFS_W-1:0];
               req_ready_d = 1'b0;
               cnt_d       = '0;
               beat_d      = '0;
               state_d     = (LATENCY == 1) ? ST_BURST : ST_WAIT;
            end
         end
         ST_WAIT: begin
            // BURST is entered one edge early: its first read registers the first beat.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(LATENCY - 2)) state_d = ST_BURST;
         end
         ST_BURST: begin
            if (resp_last_q) begin
               state_d     = ST_IDLE;
               req_ready_d = 1'b1;
            end else begin
               issue        = 1'b1;
               resp_valid_d = 1'b1;
               resp_word_d  = ofs_q;
               resp_last_d  = (beat_q == OFS_W'(BLK_WORDS - 1));
               ofs_d        = ofs_q + 1'b1;
               beat_d       = beat_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_last_q  <= 1'b0;
         resp_word_q  <= '0;
         cnt_q        <= '0;
         beat_q       <= '0;
         ofs_q        <= '0;
         base_q       <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_last_q  <= resp_last_d;
         resp_word_q  <= resp_word_d;
         cnt_q        <= cnt_d;
         beat_q       <= beat_d;
         ofs_q        <= ofs_d;
         base_q       <= base_d;
      end
   end

   block_refill_responder_mem_array_1r1w #(
      .WORD_W (WORD_W),
      .DEPTH  (MEM_WORDS),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (bus.wr_en),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
      .rd_en_i   (issue),
      .rd_addr_i ({base_q, ofs_q}),
      .rd_data_o (rd_data)
   );

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_last  = resp_last_q;
   assign bus.resp_word  = resp_word_q;
   assign bus.resp_data  = rd_data;

endmodule

// File: tb/tb_block_refill_responder.sv
// Scoreboard bench: drivers push expected beats (word, data, last, edge number),
// per-DUT monitors pop and compare on every resp_valid. Two builds: LATENCY 8 and 1.
module tb_block_refill_responder;

   typedef struct {
      logic [3:0]  word;
      logic [31:0] data;
      logic        last;
      int          at_edge;
   } beat_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_err;
   bit   mon_en;

   logic [31:0] model [4096];
   beat_t q8[$];
   beat_t q1[$];
   beat_t m8;
   beat_t m1;

   block_refill_responder_if #(.WORD_W(32)) bus8 ();
   block_refill_responder_if #(.WORD_W(32)) bus1 ();

   assign bus1.wr_en   = bus8.wr_en;
   assign bus1.wr_addr = bus8.wr_addr;
   assign bus1.wr_data = bus8.wr_data;

   block_refill_responder #(.WORD_W(32), .MEM_WORDS(4096), .LATENCY(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   block_refill_responder #(.WORD_W(32), .MEM_WORDS(4096), .LATENCY(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic beat_t exp_beat(input logic [31:0] a, input int i, input int first);
      beat_t      b;
      logic [3:0] w;
      w         = a[3:0] + 4'(i);
      b.word    = w;
      b.data    = model[{a[11:4], w}];
      b.last    = (i == 15);
      b.at_edge = first + i;
      return b;
   endfunction

   always @(negedge clk) begin
      if (mon_en && bus8.resp_valid !== 1'b0) begin
         if (q8.size() == 0) check("spurious_beat8", 32'(bus8.resp_valid), 32'd0);
         else begin
            m8 = q8.pop_front();
            check("beat_edge8", cyc, m8.at_edge);
            check("resp_word8", 32'(bus8.resp_word), 32'(m8.word));
            check("resp_data8", bus8.resp_data, m8.data);
            check("resp_last8", 32'(bus8.resp_last), 32'(m8.last));
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en && bus1.resp_valid !== 1'b0) begin
         if (q1.size() == 0) check("spurious_beat1", 32'(bus1.resp_valid), 32'd0);
         else begin
            m1 = q1.pop_front();
            check("beat_edge1", cyc, m1.at_edge);
            check("resp_word1", 32'(bus1.resp_word), 32'(m1.word));
            check("resp_data1", bus1.resp_data, m1.data);
            check("resp_last1", 32'(bus1.resp_last), 32'(m1.last));
         end
      end
   end

   // All driver tasks are entered and left on a falling edge.
   task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
      bus8.wr_en   = 1'b1;
      bus8.wr_addr = a;
      bus8.wr_data = d;
      @(negedge clk);
      model[a[11:0]] = d;
      bus8.wr_en     = 1'b0;
   endtask

   task automatic request8(input logic [31:0] a);
      check("req_ready8_before", 32'(bus8.req_ready), 32'd1);
      bus8.req_valid = 1'b1;
      bus8.req_addr  = a;
      for (int i = 0; i < 16; i++) q8.push_back(exp_beat(a, i, cyc + 1 + 8));
      @(negedge clk);
      bus8.req_valid = 1'b0;
   endtask

   task automatic request1(input logic [31:0] a);
      check("req_ready1_before", 32'(bus1.req_ready), 32'd1);
      bus1.req_valid = 1'b1;
      bus1.req_addr  = a;
      for (int i = 0; i < 16; i++) q1.push_back(exp_beat(a, i, cyc + 1 + 1));
      @(negedge clk);
      bus1.req_valid = 1'b0;
   endtask

   task automatic wait_idle8();
      for (int i = 0; i < 100 && !(q8.size() == 0 && bus8.req_ready === 1'b1); i++) @(negedge clk);
      check("drain8_pending", q8.size(), 32'd0);
      check("req_ready8_after", 32'(bus8.req_ready), 32'd1);
   endtask

   task automatic wait_idle1();
      for (int i = 0; i < 100 && !(q1.size() == 0 && bus1.req_ready === 1'b1); i++) @(negedge clk);
      check("drain1_pending", q1.size(), 32'd0);
      check("req_ready1_after", 32'(bus1.req_ready), 32'd1);
   endtask

   task automatic wait_edge(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready8"},  32'(bus8.req_ready),  32'd1);
      check({tag, "_resp_valid8"}, 32'(bus8.resp_valid), 32'd0);
      check({tag, "_resp_last8"},  32'(bus8.resp_last),  32'd0);
      check({tag, "_req_ready1"},  32'(bus1.req_ready),  32'd1);
      check({tag, "_resp_valid1"}, 32'(bus1.resp_valid), 32'd0);
   endtask

   initial begin
      int c;
      n_cmp = 0;
      n_err = 0;
      mon_en = 1'b0;
      rst = 1'b1;
      bus8.req_valid = 1'b0;
      bus8.req_addr  = '0;
      bus8.wr_en     = 1'b0;
      bus8.wr_addr   = '0;
      bus8.wr_data   = '0;
      bus1.req_valid = 1'b0;
      bus1.req_addr  = '0;

      // Reset held for three edges; outputs defined from the first one.
      @(negedge clk);
      check_reset_outputs("rst_first_edge");
      check("rst_resp_data8", bus8.resp_data, 32'd0);
      check("rst_resp_word8", 32'(bus8.resp_word), 32'd0);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) mem_write(32'h40 + 32'(i), 32'hA000 + 32'(i));
      for (int i = 0; i < 16; i++) mem_write(32'h80 + 32'(i), 32'hB000 + 32'(i));

      // Aligned refill.
      request8(32'h40);
      wait_idle8();

      // Critical word first.
      request8(32'h4B);
      wait_idle8();

      // Busy: valid held throughout; second request taken when req_ready returns.
      c = cyc;
      bus8.req_valid = 1'b1;
      bus8.req_addr  = 32'h4B;
      for (int i = 0; i < 16; i++) q8.push_back(exp_beat(32'h4B, i, c + 1 + 8));
      for (int i = 0; i < 16; i++) q8.push_back(exp_beat(32'h80, i, c + 26 + 8));
      @(negedge clk);
      bus8.req_addr = 32'h80;
      wait_edge(c + 24);
      check("busy_req_ready_last_beat", 32'(bus8.req_ready), 32'd0);
      @(negedge clk);
      check("busy_req_ready_returns", 32'(bus8.req_ready), 32'd1);
      @(negedge clk);
      bus8.req_valid = 1'b0;
      check("busy_second_accepted", 32'(bus8.req_ready), 32'd0);
      wait_idle8();

      // Write collides with the read of beat 5: beat keeps old data.
      c = cyc;
      request8(32'h40);
      wait_edge(c + 13);
      bus8.wr_en   = 1'b1;
      bus8.wr_addr = 32'h45;
      bus8.wr_data = 32'hDEAD;
      @(negedge clk);
      model[12'h045] = 32'hDEAD;
      bus8.wr_en     = 1'b0;
      wait_idle8();
      request8(32'h40);
      wait_idle8();

      // LATENCY=1 build: first beat one edge after accept.
      request1(32'h80);
      wait_idle1();
      request1(32'h8F);
      wait_idle1();

      // Reset after beat 3 aborts the burst.
      c = cyc;
      request8(32'h40);
      wait_edge(c + 12);
      #1;
      check("beats_before_reset", 32'(16 - q8.size()), 32'd4);
      rst = 1'b1;
      q8.delete();
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_mid_burst");
      rst = 1'b0;
      repeat (20) @(negedge clk);
      request8(32'h80);
      wait_idle8();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
